// File: rtl/visitor_dir_counter_pkg.sv
// visitor_dir_counter_pkg: shared FSM state encoding and default sizing for the visitor direction counter
package visitor_pkg;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_MAX_COUNT = 99;
  localparam int DEF_TIMEOUT   = 1000;
  typedef enum logic [2:0] {
    IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_BA, EXT_A, WAIT_CLR
  } state_t;
endpackage

// File: rtl/visitor_dir_counter_occupancy_counter.sv
// occupancy_counter: saturating up/down occupancy counter
// Ports: clk, rst_n (async active-low); inc/dec requests in;
// count, full (count==MAX_COUNT), empty (count==0) out;
// sat_err flags a request refused because the counter is at its limit.
module occupancy_counter
  import visitor_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             sat_err
);
  assign full    = count == CNT_W'(MAX_COUNT);
  assign empty   = count == '0;
  assign sat_err = (inc && full) || (dec && empty);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !full) count <= count + 1'b1;
    else if (dec && !empty) count <= count - 1'b1;
endmodule

// File: rtl/visitor_dir_counter.sv
// visitor_dir_counter: decodes door-sensor trip order into entries/exits and keeps occupancy
// Ports: clk, rst_n (async active-low); sens_a (outer), sens_b (inner) beam-broken inputs;
// count, full, empty occupancy outputs; inc_pulse/dec_pulse on committed entry/exit;
// err_pulse on overflow, underflow, ambiguous trip or stalled-sequence timeout.
// Macro SENSOR_SYNC_EN: adds a two-flop synchronizer on each sensor (responses 2 cycles later).
module visitor_dir_counter
  import visitor_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sens_a,
  input  logic             sens_b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             err_pulse
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] ab;
  state_t state, seq_nxt, nxt;
  logic [TW-1:0] tmo;
  logic ent, ext, amb, active, tmo_hit, sat_err;
`ifdef SENSOR_SYNC_EN
  logic [1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sens_a, sens_b};
      s2 <= s1;
    end
  assign ab = s2;
`else
  assign ab = {sens_a, sens_b};
`endif
  always_comb begin
    seq_nxt = state;
    ent = 1'b0;
    ext = 1'b0;
    amb = 1'b0;
    case (state)
      IDLE: begin
        seq_nxt = ab == 2'b10 ? ENT_A : ab == 2'b01 ? EXT_B : ab == 2'b11 ? WAIT_CLR : IDLE;
        amb = ab == 2'b11;
      end
      ENT_A:  seq_nxt = ab == 2'b11 ? ENT_AB : ab == 2'b01 ? ENT_B : ab == 2'b00 ? IDLE : ENT_A;
      ENT_AB: begin
        seq_nxt = ab == 2'b01 ? ENT_B : ab == 2'b10 ? ENT_A : ab == 2'b00 ? IDLE : ENT_AB;
        ent = ab == 2'b00;
      end
      ENT_B: begin
        seq_nxt = ab == 2'b11 ? ENT_AB : ab == 2'b10 ? ENT_A : ab == 2'b00 ? IDLE : ENT_B;
        ent = ab == 2'b00;
      end
      EXT_B:  seq_nxt = ab == 2'b11 ? EXT_BA : ab == 2'b10 ? EXT_A : ab == 2'b00 ? IDLE : EXT_B;
      EXT_BA: begin
        seq_nxt = ab == 2'b10 ? EXT_A : ab == 2'b01 ? EXT_B : ab == 2'b00 ? IDLE : EXT_BA;
        ext = ab == 2'b00;
      end
      EXT_A: begin
        seq_nxt = ab == 2'b11 ? EXT_BA : ab == 2'b01 ? EXT_B : ab == 2'b00 ? IDLE : EXT_A;
        ext = ab == 2'b00;
      end
      default: seq_nxt = ab == 2'b00 ? IDLE : WAIT_CLR;
    endcase
    active = state != IDLE && state != WAIT_CLR;
    // tmo counts repeats of the current state, so the abort lands after TIMEOUT cycles stalled
    tmo_hit = active && seq_nxt == state && tmo == TW'(TIMEOUT - 1);
    nxt = tmo_hit ? WAIT_CLR : seq_nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      tmo       <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= nxt;
      tmo       <= (active && nxt == state) ? tmo + 1'b1 : '0;
      inc_pulse <= ent && !full;
      dec_pulse <= ext && !empty;
      err_pulse <= amb || tmo_hit || sat_err;
    end
  occupancy_counter #(.CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (ent),
    .dec     (ext),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .sat_err (sat_err)
  );
endmodule

// File: tb/tb_visitor_dir_counter.sv
// tb_visitor_dir_counter: randomized and directed check of visitor_dir_counter against a behavioural model
module tb_visitor_dir_counter;
  localparam int CNT_W = 8, MAX_COUNT = 99, TIMEOUT = 10;
`ifdef SENSOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 0, rst_n = 0, sens_a = 0, sens_b = 0;
  logic [CNT_W-1:0] count;
  logic full, empty, inc_pulse, dec_pulse, err_pulse;
  int n_tot = 0, n_pass = 0, n_inc = 0, n_dec = 0, n_err = 0;
  // mode: 0 idle, 1 entry in progress, 2 exit in progress, 3 blocked until both beams clear
  typedef struct packed {
    int mode;
    logic [1:0] last;
    int hold;
    int cnt;
    logic inc, dec, err;
  } model_t;
  model_t m;

  visitor_dir_counter #(.CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sens_a(sens_a), .sens_b(sens_b),
    .count(count), .full(full), .empty(empty),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // A sequence is the run of nonzero sensor patterns starting from idle; it counts when
  // both beams clear and the last pattern seen had the far-side beam broken.
  function automatic model_t model_step(input model_t s, input logic [1:0] p);
    model_t n = s;
    n.inc = 0; n.dec = 0; n.err = 0;
    if (s.mode == 3) begin
      if (p == 2'b00) n.mode = 0;
    end else if (s.mode == 0) begin
      if (p == 2'b11) begin n.mode = 3; n.err = 1; end
      else if (p != 2'b00) begin n.mode = (p == 2'b10) ? 1 : 2; n.last = p; n.hold = 0; end
    end else if (p == 2'b00) begin
      n.mode = 0;
      if (s.mode == 1 && s.last[0]) begin
        if (s.cnt < MAX_COUNT) begin n.cnt = s.cnt + 1; n.inc = 1; end
        else n.err = 1;
      end else if (s.mode == 2 && s.last[1]) begin
        if (s.cnt > 0) begin n.cnt = s.cnt - 1; n.dec = 1; end
        else n.err = 1;
      end
    end else if (p == s.last) begin
      n.hold = s.hold + 1;
      if (n.hold == TIMEOUT) begin n.mode = 3; n.err = 1; end
    end else begin
      n.last = p; n.hold = 0;
    end
    return n;
  endfunction

`ifdef SENSOR_SYNC_EN
  logic [1:0] p1, p2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin m <= '0; p1 <= '0; p2 <= '0; end
    else begin
      p1 <= {sens_a, sens_b};
      p2 <= p1;
      m  <= model_step(m, p2);
    end
`else
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '0;
    else m <= model_step(m, {sens_a, sens_b});
`endif

  always @(negedge clk) begin
    check("count", int'(count), m.cnt);
    check("full", int'(full), int'(m.cnt == MAX_COUNT));
    check("empty", int'(empty), int'(m.cnt == 0));
    check("inc_pulse", int'(inc_pulse), int'(m.inc));
    check("dec_pulse", int'(dec_pulse), int'(m.dec));
    check("err_pulse", int'(err_pulse), int'(m.err));
    n_inc += int'(inc_pulse);
    n_dec += int'(dec_pulse);
    n_err += int'(err_pulse);
  end

  task automatic step(input logic [1:0] p);
    @(negedge clk);
    {sens_a, sens_b} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic entry();
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    repeat (LAT + 1) step(2'b00);
  endtask

  task automatic exit_walk();
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    repeat (LAT + 1) step(2'b00);
  endtask

  initial begin
    int i0, d0, e0, k;
    logic [1:0] pat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_pulses", int'({inc_pulse, dec_pulse, err_pulse}), 0);
    @(negedge clk);
    rst_n = 1;
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    repeat (LAT) step(2'b00);
    check("walk_inc_hi", int'(inc_pulse), 1);
    check("walk_count", int'(count), 1);
    check("walk_empty", int'(empty), 0);
    step(2'b00);
    check("walk_inc_lo", int'(inc_pulse), 0);
    entry(); entry();
    check("three_count", int'(count), 3);
    d0 = n_dec;
    exit_walk();
    check("exit_count", int'(count), 2);
    check("exit_dec", n_dec - d0, 1);
    i0 = n_inc; e0 = n_err;
    step(2'b10); step(2'b00);
    repeat (LAT + 1) step(2'b00);
    check("backout_count", int'(count), 2);
    check("backout_pulses", n_inc - i0 + n_err - e0, 0);
    e0 = n_err;
    step(2'b11); step(2'b01); step(2'b00);
    repeat (LAT + 1) step(2'b00);
    check("amb_count", int'(count), 2);
    check("amb_err", n_err - e0, 1);
    repeat (97) entry();
    check("fill_count", int'(count), 99);
    check("fill_full", int'(full), 1);
    i0 = n_inc; e0 = n_err;
    entry();
    check("ovf_count", int'(count), 99);
    check("ovf_err", n_err - e0, 1);
    check("ovf_inc", n_inc - i0, 0);
    repeat (99) exit_walk();
    check("drain_count", int'(count), 0);
    d0 = n_dec; e0 = n_err;
    exit_walk();
    check("unf_count", int'(count), 0);
    check("unf_err", n_err - e0, 1);
    check("unf_dec", n_dec - d0, 0);
    e0 = n_err; i0 = n_inc;
    for (int i = 1; i <= 12 + LAT; i++) begin
      step(2'b10);
      if (i == 10 + LAT) check("tmo_early", int'(err_pulse), 0);
      if (i == 11 + LAT) check("tmo_err", int'(err_pulse), 1);
    end
    step(2'b11); step(2'b01); step(2'b00);
    repeat (LAT + 1) step(2'b00);
    check("tmo_err_once", n_err - e0, 1);
    check("tmo_no_inc", n_inc - i0, 0);
    repeat (5) entry();
    check("pre_rst_count", int'(count), 5);
    step(2'b10); step(2'b11);
    repeat (LAT) step(2'b11);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_empty", int'(empty), 1);
    {sens_a, sens_b} = 2'b00;
    @(negedge clk);
    rst_n = 1;
    i0 = n_inc;
    repeat (LAT + 3) step(2'b00);
    check("post_rst_count", int'(count), 0);
    check("post_rst_inc", n_inc - i0, 0);
    repeat (400) begin
      k = $urandom_range(0, 3);
      if (k == 0 || k == 1) begin
        step(k == 0 ? 2'b10 : 2'b01);
        repeat ($urandom_range(0, 3)) begin
          pat = 2'($urandom_range(1, 3));
          step(pat);
        end
        step(2'b00);
      end else if (k == 2) begin
        pat = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 12)) step(pat);
      end else step(2'b00);
    end
    repeat (LAT + 2) step(2'b00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
